alu_mc: RTL and testbench

Multi-cycle, parametrised integer execute unit succeeding the single-cycle RV32 ALU. It executes the base ALU operation set in one registered cycle and the RISC-V M-extension operations (multiply and divide/remainder, signed and unsigned) iteratively over XLEN cycles. It sits in the execute stage behind a valid/ready handshake, so the pipeline stalls on long operations.

---
 rtl/alu_mc.sv | 235 +++++++++++++++++++++++
 tb/tb_alu_mc.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle RV32-style execute unit.
// Base ALU ops complete in one registered cycle; M-extension multiply and
// divide/remainder iterate over XLEN cycles behind a valid/ready handshake.
// Optional feature macro: ALU_MC_DIV_EN (defined = divider present; undefined =
// M ops 4-7 report illegal with base-op latency).
module alu_mc #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      funct,
  input  logic            mext,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] o,
  output logic            zero,
  output logic            illegal
);

  localparam int unsigned SHW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StBusy, StFix, StDone} state_e;

  state_e              state_q, state_d;
  logic [SHW-1:0]      cnt_q, cnt_d;
  logic [2:0]          fn_q, fn_d;
  logic                sa_q, sa_d;
  logic                sb_q, sb_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     o_q, o_d;
  logic                zero_q, zero_d;
  logic                illegal_q, illegal_d;
`ifdef ALU_MC_DIV_EN
  logic [XLEN-1:0]     a_q, a_d;
  logic                bzero_q, bzero_d;
`endif

  logic [SHW-1:0]      shamt;
  logic [XLEN-1:0]     base_res;
  logic                m_sa, m_sb;
  logic [XLEN-1:0]     ma, mb;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     mul_res;
  logic [XLEN-1:0]     fix_res;
`ifdef ALU_MC_DIV_EN
  logic [XLEN:0]       rem_sh;
  logic [XLEN:0]       div_diff;
  logic [2*XLEN-1:0]   div_next;
  logic [XLEN-1:0]     quo_s, rem_s;
`endif

  // Single-cycle base ALU result from the live operands.
  always_comb begin
    shamt    = b[SHW-1:0];
    base_res = '0;
    unique case (funct[2:0])
      3'd0: base_res = funct[3] ? (a - b) : (a + b);
      3'd1: base_res = a << shamt;
      3'd2: base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      3'd3: base_res = {{(XLEN-1){1'b0}}, (a < b)};
      3'd4: base_res = a ^ b;
      3'd5: begin
        if (funct[3]) base_res = $unsigned($signed(a) >>> shamt);
        else          base_res = a >> shamt;
      end
      3'd6: base_res = a | b;
      3'd7: base_res = a & b;
    endcase
  end

  // Operand signedness and magnitudes for the iterative datapath.
  always_comb begin
    // MULHU, DIVU, REMU treat A as unsigned; MULHSU additionally treats B as unsigned.
    m_sa = a[XLEN-1] && !(funct[2:0] == 3'd3 || funct[2:0] == 3'd5 || funct[2:0] == 3'd7);
    m_sb = b[XLEN-1] && (funct[2:0] == 3'd0 || funct[2:0] == 3'd1 ||
                         funct[2:0] == 3'd4 || funct[2:0] == 3'd6);
    ma   = m_sa ? (~a + 1'b1) : a;
    mb   = m_sb ? (~b + 1'b1) : b;
  end

  // One iteration step: shift-add multiply (and restoring divide when built in).
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
`ifdef ALU_MC_DIV_EN
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    div_diff = rem_sh - {1'b0, opb_q};
    if (div_diff[XLEN]) div_next = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    else                div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
`endif
  end

  // Final sign correction and half / quotient / remainder selection.
  always_comb begin
    prod    = (sa_q ^ sb_q) ? (~acc_q + 1'b1) : acc_q;
    mul_res = (fn_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    fix_res = mul_res;
`ifdef ALU_MC_DIV_EN
    // Signed overflow (most-negative / -1) needs no special path: the magnitude
    // quotient is 2^(XLEN-1), whose negation is itself, and the remainder is 0.
    if (bzero_q) begin
      quo_s = '1;
      rem_s = a_q;
    end else begin
      quo_s = (sa_q ^ sb_q) ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
      rem_s = sa_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    end
    if (fn_q[2]) fix_res = fn_q[1] ? rem_s : quo_s;
`endif
  end

  // Control FSM and datapath next-state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fn_d      = fn_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    o_d       = o_q;
    illegal_d = illegal_q;
`ifdef ALU_MC_DIV_EN
    a_d       = a_q;
    bzero_d   = bzero_q;
`endif
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            if (!mext) begin
              o_d       = base_res;
              illegal_d = 1'b0;
              state_d   = StDone;
            end
`ifndef ALU_MC_DIV_EN
            else if (funct[2]) begin
              o_d       = '0;
              illegal_d = 1'b1;
              state_d   = StDone;
            end
`endif
            else begin
              fn_d    = funct[2:0];
              sa_d    = m_sa;
              sb_d    = m_sb;
              opb_d   = mb;
              acc_d   = {{XLEN{1'b0}}, ma};
              cnt_d   = '0;
              state_d = StBusy;
`ifdef ALU_MC_DIV_EN
              a_d     = a;
              bzero_d = (b == '0);
`endif
            end
          end
        end
        StBusy: begin
          acc_d = mul_next;
`ifdef ALU_MC_DIV_EN
          if (fn_q[2]) acc_d = div_next;
`endif
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == SHW'(XLEN - 1)) begin
            cnt_d   = '0;
            state_d = StFix;
          end
        end
        StFix: begin
          o_d       = fix_res;
          illegal_d = 1'b0;
          state_d   = StDone;
        end
        StDone: begin
          if (out_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
    zero_d = (o_d == '0);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      fn_q      <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      opb_q     <= '0;
      acc_q     <= '0;
      o_q       <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
`ifdef ALU_MC_DIV_EN
      a_q       <= '0;
      bzero_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fn_q      <= fn_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      o_q       <= o_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
`ifdef ALU_MC_DIV_EN
      a_q       <= a_d;
      bzero_q   <= bzero_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign o         = o_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (XLEN=32): directed cases, handshake,
// flush/reset behaviour and randomized ops against a behavioural model.
module tb_alu_mc;
  localparam int XLEN = 32;
`ifdef ALU_MC_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  funct = '0;
  logic        mext = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] o;
  logic        zero;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_mc #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .funct     (funct),
    .mext      (mext),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .zero      (zero),
    .illegal   (illegal)
  );

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: {illegal, result} from plain arithmetic on the ISA definitions.
  function automatic logic [32:0] ref_model(input bit m, input logic [3:0] f,
                                            input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    logic [31:0] r;
    int          ix, iy;
    bit          sgn, want_rem;
    r = '0;
    if (!m) begin
      case (f[2:0])
        3'd0: r = f[3] ? x - y : x + y;
        3'd1: r = x << y[4:0];
        3'd2: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        3'd3: r = (x < y) ? 32'd1 : 32'd0;
        3'd4: r = x ^ y;
        3'd5: r = f[3] ? 32'(longint'($signed(x)) >>> y[4:0]) : x >> y[4:0];
        3'd6: r = x | y;
        default: r = x & y;
      endcase
      return {1'b0, r};
    end
    case (f[2:0])
      3'd0: r = x * y;
      3'd1: begin p = longint'($signed(x)) * longint'($signed(y)); r = p[63:32]; end
      3'd2: begin p = longint'($signed(x)) * longint'({32'b0, y}); r = p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; r = p[63:32]; end
      default: begin
        if (!DivEn) return {1'b1, 32'b0};
        sgn = !f[0];
        want_rem = f[1];
        if (y == 0) r = want_rem ? x : 32'hFFFF_FFFF;
        else if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = want_rem ? 32'd0 : x;
        else if (sgn) begin
          ix = $signed(x);
          iy = $signed(y);
          r = want_rem ? 32'(ix % iy) : 32'(ix / iy);
        end else r = want_rem ? x % y : x / y;
      end
    endcase
    return {1'b0, r};
  endfunction

  function automatic int ref_lat(input bit m, input logic [3:0] f);
    if (!m) return 1;
    if (f[2] && !DivEn) return 1;
    return XLEN + 2;
  endfunction

  // Issue one op, scramble operands after accept, wait for result, hand it off.
  task automatic run_op(input bit m, input logic [3:0] f, input logic [31:0] av,
                        input logic [31:0] bv, output logic [31:0] o_r,
                        output logic z_r, output logic il_r, output int lat);
    int g;
    @(negedge clk);
    mext = m; funct = f; a = av; b = bv; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 100) begin @(negedge clk); g++; end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    o_r = o; z_r = zero; il_r = illegal;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (o !== 32'h0) begin errors++; $display("FAIL reset_o: got %h want 0", o); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", zero); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    rst_n = 1'b1;
  endtask

  task automatic test_base();
    logic [3:0]  fs[5] = '{4'b1000, 4'b1101, 4'b0010, 4'b1000, 4'b0000};
    logic [31:0] as[5] = '{32'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd3, 32'd2};
    logic [31:0] bs[5] = '{32'd7, 32'd4, 32'd1, 32'd3, 32'd3};
    logic [31:0] es[5] = '{32'hFFFF_FFFE, 32'hF800_0000, 32'd1, 32'd0, 32'd5};
    logic [31:0] r; logic z, il; int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, fs[i], as[i], bs[i], r, z, il, lat);
      checks++; if (r !== es[i]) begin errors++; $display("FAIL base%0d_o: got %h want %h", i, r, es[i]); end
      checks++; if (z !== (es[i] == 0)) begin errors++; $display("FAIL base%0d_zero: got %b want %b", i, z, es[i] == 0); end
      checks++; if (il !== 1'b0) begin errors++; $display("FAIL base%0d_illegal: got %b want 0", i, il); end
      checks++; if (lat != 1) begin errors++; $display("FAIL base%0d_latency: got %0d want 1", i, lat); end
    end
  endtask

  task automatic test_mul();
    logic [31:0] as[4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs[4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] es[4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic [31:0] r; logic z, il; int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b1, 4'(i), as[i], bs[i], r, z, il, lat);
      checks++; if (r !== es[i]) begin errors++; $display("FAIL mul%0d_o: got %h want %h", i, r, es[i]); end
      checks++; if (lat != XLEN + 2) begin errors++; $display("FAIL mul%0d_latency: got %0d want %0d", i, lat, XLEN + 2); end
    end
  endtask

`ifdef ALU_MC_DIV_EN
  task automatic test_div();
    logic [3:0]  fs[6] = '{4'd4, 4'd6, 4'd5, 4'd6, 4'd4, 4'd6};
    logic [31:0] as[6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h1234_5678, 32'd9,
                           32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs[6] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] es[6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9,
                           32'h8000_0000, 32'd0};
    logic [31:0] r; logic z, il; int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(1'b1, fs[i], as[i], bs[i], r, z, il, lat);
      checks++; if (r !== es[i]) begin errors++; $display("FAIL div%0d_o: got %h want %h", i, r, es[i]); end
      checks++; if (z !== (es[i] == 0)) begin errors++; $display("FAIL div%0d_zero: got %b want %b", i, z, es[i] == 0); end
      checks++; if (il !== 1'b0) begin errors++; $display("FAIL div%0d_illegal: got %b want 0", i, il); end
      checks++; if (lat != XLEN + 2) begin errors++; $display("FAIL div%0d_latency: got %0d want %0d", i, lat, XLEN + 2); end
    end
  endtask
`else
  task automatic test_div_disabled();
    logic [31:0] r; logic z, il; int lat;
    run_op(1'b1, 4'd4, 32'd8, 32'd2, r, z, il, lat);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL nodiv_o: got %h want 0", r); end
    checks++; if (z !== 1'b1) begin errors++; $display("FAIL nodiv_zero: got %b want 1", z); end
    checks++; if (il !== 1'b1) begin errors++; $display("FAIL nodiv_illegal: got %b want 1", il); end
    checks++; if (lat != 1) begin errors++; $display("FAIL nodiv_latency: got %0d want 1", lat); end
    run_op(1'b1, 4'd0, 32'd3, 32'd4, r, z, il, lat);
    checks++; if (r !== 32'd12) begin errors++; $display("FAIL nodiv_mul_o: got %h want 0000000c", r); end
    checks++; if (il !== 1'b0) begin errors++; $display("FAIL nodiv_mul_illegal: got %b want 0", il); end
  endtask
`endif

  task automatic test_backpressure();
    logic [31:0] exp_o; int g;
    exp_o = ref_model(1'b1, 4'd0, 32'd1234, 32'd5678);
    @(negedge clk);
    mext = 1'b1; funct = 4'd0; a = 32'd1234; b = 32'd5678; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom;
    g = 0;
    while (!out_valid && g < 100) begin @(negedge clk); g++; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d: got %b want 1", i, out_valid); end
      checks++; if (o !== exp_o) begin errors++; $display("FAIL bp_o%0d: got %h want %h", i, o, exp_o); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d: got %b want 0", i, in_ready); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int g;
    @(negedge clk);
    mext = 1'b0; funct = 4'd6; a = 32'h00F0; b = 32'h000F; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Result is waiting; request a new op in the same cycle as the handoff.
    funct = 4'd4; a = 32'hFF00; b = 32'h0FF0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_accept_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid: got %b want 1", out_valid); end
    checks++; if (o !== 32'hF0F0) begin errors++; $display("FAIL b2b_second_o: got %h want 0000f0f0", o); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    g = 0;
  endtask

  task automatic test_flush();
    int seen;
    // Flush during BUSY.
    @(negedge clk);
    mext = 1'b1; funct = 4'd3; a = 32'hDEAD_BEEF; b = 32'h1234_5678; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_busy_in_ready: got %b want 1", in_ready); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_busy_no_result: got %0d valid cycles want 0", seen); end
    // Flush in DONE drops the result.
    mext = 1'b0; funct = 4'd0; a = 32'd1; b = 32'd1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_done_pre: got %b want 1", out_valid); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_done_valid: got %b want 0", out_valid); end
    // Flush with in_valid in IDLE accepts nothing.
    flush = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_idle_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_idle_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] r; logic z, il; int lat;
    @(negedge clk);
    mext = 1'b1; funct = DivEn ? 4'd4 : 4'd0; a = 32'd1000; b = 32'd7; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_busy_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_busy_in_ready: got %b want 1", in_ready); end
    checks++; if (o !== 32'h0) begin errors++; $display("FAIL rst_busy_o: got %h want 0", o); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 4'd0, 32'd2, 32'd3, r, z, il, lat);
    checks++; if (r !== 32'd5) begin errors++; $display("FAIL rst_add_o: got %h want 5", r); end
    checks++; if (lat != 1) begin errors++; $display("FAIL rst_add_latency: got %0d want 1", lat); end
  endtask

  task automatic test_random();
    logic [31:0] x, y, r; logic z, il; logic [3:0] f; bit m; int lat;
    logic [32:0] exp_v; int exp_l;
    logic [31:0] specials[4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1};
    for (int i = 0; i < 150; i++) begin
      m = 1'($urandom);
      f = 4'($urandom);
      x = ($urandom_range(0, 7) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      y = ($urandom_range(0, 7) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      exp_v = ref_model(m, f, x, y);
      exp_l = ref_lat(m, f);
      run_op(m, f, x, y, r, z, il, lat);
      checks++; if (r !== exp_v[31:0]) begin errors++; $display("FAIL rnd%0d_o m=%0d f=%h a=%h b=%h: got %h want %h", i, m, f, x, y, r, exp_v[31:0]); end
      checks++; if (z !== (exp_v[31:0] == 0)) begin errors++; $display("FAIL rnd%0d_zero: got %b want %b", i, z, exp_v[31:0] == 0); end
      checks++; if (il !== exp_v[32]) begin errors++; $display("FAIL rnd%0d_illegal: got %b want %b", i, il, exp_v[32]); end
      checks++; if (lat != exp_l) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, exp_l); end
    end
  endtask

  initial begin
    test_reset();
    test_base();
    test_mul();
`ifdef ALU_MC_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
